// File: rtl/hc_pkg.sv
// Shared definitions for the Hamming(21,16)+overall-parity SECDED codec.
// The encode function lives here so the decoder can rebuild reference
// codewords when it computes syndromes.
package hc_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 22;
    localparam int NPAR   = 5;

    typedef logic [DATA_W-1:0] hc_data_t;
    typedef logic [CODE_W-1:0] hc_code_t;

    // Places data bits at the non-power-of-two positions 3..21, fills the
    // parity bits at 1,2,4,8,16, then sets bit 0 to even parity over 21:1.
    function automatic hc_code_t hc_encode(input hc_data_t data);
        hc_code_t code;
        int       di;
        logic     par;
        code = '0;
        di   = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                code[p] = data[di];
                di++;
            end
        end
        // Parity slots are still zero here, so including them is harmless.
        for (int k = 0; k < NPAR; k++) begin
            par = 1'b0;
            for (int p = 1; p < CODE_W; p++) begin
                if (((p >> k) & 1) == 1) begin
                    par = par ^ code[p];
                end
            end
            code[1 << k] = par;
        end
        code[0] = ^code[CODE_W-1:1];
        return code;
    endfunction

endpackage

// File: rtl/hc_encoder_stage_fifo.sv
// hc_sync_fifo: small synchronous FIFO with full/empty flags.
// DEPTH must be a power of two (2 or 4 here) so pointers wrap naturally.
// Storage is reset so a stale word can never reappear after reset.
module hc_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count_q == OCC_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // One register per entry, loaded when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (do_wr && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Pointers and occupancy; simultaneous write and read leave occupancy alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hc_encoder_stage.sv
// hc_encoder_stage: SECDED-encodes LFSR data words and buffers the
// codewords in a small FIFO behind valid/ready handshakes.
// Optional error injection is compiled in with `define HC_ERR_INJECT_EN.
module hc_encoder_stage
    import hc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef HC_ERR_INJECT_EN
    input  logic              inj_en,
    input  logic [4:0]        inj_pos,
    input  logic [4:0]        inj_pos2,
    input  logic              inj_double,
    input  logic [7:0]        inj_period,
`endif
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              fifo_full
);

    hc_code_t         clean_code;
    hc_code_t         wr_code;
    logic             accept;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] word_cnt_q;

    assign clean_code = hc_encode(in_data);
    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign word_cnt   = word_cnt_q;

`ifdef HC_ERR_INJECT_EN
    logic [7:0] inj_cnt_q;
    logic       inj_hit;
    hc_code_t   inj_mask;

    assign inj_hit = inj_en && (inj_period != 8'd0) && ((inj_cnt_q + 8'd1) == inj_period);

    // Counts accepted words while injection is enabled; dropping inj_en restarts it.
    always_ff @(posedge clk) begin
        if (rst || !inj_en) begin
            inj_cnt_q <= 8'd0;
        end else if (accept) begin
            inj_cnt_q <= inj_hit ? 8'd0 : inj_cnt_q + 8'd1;
        end
    end

    // Flip mask for the selected word; positions above 21 select nothing.
    always_comb begin
        inj_mask = '0;
        if (inj_hit) begin
            if (inj_pos <= 5'd21) begin
                inj_mask[inj_pos] = 1'b1;
            end
            if (inj_double && (inj_pos2 <= 5'd21)) begin
                inj_mask[inj_pos2] = inj_mask[inj_pos2] ^ 1'b1;
            end
        end
    end

    assign wr_code = clean_code ^ inj_mask;
`else
    assign wr_code = clean_code;
`endif

    // Accepted-word counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (accept) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    hc_sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_data (wr_code),
        .rd_en   (pop),
        .rd_data (out_code),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_hc_encoder_stage.sv
// Directed bench for hc_encoder_stage with a codeword scoreboard.
module tb_hc_encoder_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [21:0] out_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;
    logic        fifo_full;
`ifdef HC_ERR_INJECT_EN
    logic        inj_en;
    logic [4:0]  inj_pos;
    logic [4:0]  inj_pos2;
    logic        inj_double;
    logic [7:0]  inj_period;
`endif

    int          passes = 0;
    int          fails  = 0;
    int          total  = 0;
    logic [21:0] sb_q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [21:0] inj_xor = 22'd0;

    always #5 clk = ~clk;

    hc_encoder_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef HC_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
        .inj_pos2   (inj_pos2),
        .inj_double (inj_double),
        .inj_period (inj_period),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_code   (out_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_cnt   (word_cnt),
        .fifo_full  (fifo_full)
    );

    // Reference encoder built from an explicit data-position table.
    function automatic logic [21:0] ref_code(input logic [15:0] d);
        int          pos [16];
        logic [21:0] c;
        pos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};
        c = 22'd0;
        for (int i = 0; i < 16; i++) begin
            c[pos[i]] = d[i];
            for (int k = 0; k < 5; k++) begin
                if (((pos[i] >> k) & 1) == 1) c[1 << k] = c[1 << k] ^ d[i];
            end
        end
        c[0] = ^c[21:1];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard pops/pushes at the negedge, then settle after posedge.
    task automatic step();
        logic        acc;
        logic        pop;
        logic [21:0] exp;
        @(negedge clk);
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        if (rst) begin
            sb_q.delete();
            exp_cnt = 16'd0;
        end else begin
            if (pop) begin
                chk("pop_has_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("pop_code", 32'(out_code), 32'(exp));
                end
            end
            if (acc) begin
                sb_q.push_back(ref_code(in_data) ^ inj_xor);
                exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [15:0] prev;
        rst       = 1'b1;
        in_data   = 16'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef HC_ERR_INJECT_EN
        inj_en     = 1'b0;
        inj_pos    = 5'd0;
        inj_pos2   = 5'd0;
        inj_double = 1'b0;
        inj_period = 8'd0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_code", 32'(out_code), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Known codewords, one cycle latency into an empty FIFO.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0000;
        step();
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_code", 32'(out_code), 32'h000000);
        chk("zero_cnt", 32'(word_cnt), 32'd1);
        in_data = 16'h0001;
        step();
        chk("one_code", 32'(out_code), 32'h00000F);
        in_data = 16'hFFFF;
        step();
        chk("ffff_code", 32'(out_code), 32'h3FFFFC);
        in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: third word is held until space frees.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        step();
        chk("bp1_full", 32'(fifo_full), 32'd0);
        chk("bp1_code", 32'(out_code), 32'(ref_code(16'h1234)));
        in_data = 16'hABCD;
        step();
        chk("bp2_full", 32'(fifo_full), 32'd1);
        chk("bp2_in_ready", 32'(in_ready), 32'd0);
        in_data = 16'h5A5A;
        step();
        chk("bp3_full", 32'(fifo_full), 32'd1);
        chk("bp3_hold", 32'(out_code), 32'(ref_code(16'h1234)));
        out_ready = 1'b1;
        step();
        chk("bp4_code", 32'(out_code), 32'(ref_code(16'hABCD)));
        chk("bp4_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp5_code", 32'(out_code), 32'(ref_code(16'h5A5A)));
        in_valid = 1'b0;
        step();
        chk("bp6_valid", 32'(out_valid), 32'd0);

        // Occupancy 1 with accept and pop every cycle.
        in_valid = 1'b1;
        prev     = 16'h0F0F;
        in_data  = prev;
        step();
        for (int i = 0; i < 10; i++) begin
            in_data = 16'($urandom);
            step();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_full", 32'(fifo_full), 32'd0);
            chk("stream_code", 32'(out_code), 32'(ref_code(in_data)));
            prev = in_data;
        end
        in_valid = 1'b0;
        step();

        // Reset with two buffered words.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        step();
        in_data = 16'hBEEF;
        step();
        chk("pre_rst_full", 32'(fifo_full), 32'd1);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt", 32'(word_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_code", 32'(out_code), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        // Counter wrap after 65536 accepts.
        in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = 16'(i * 7);
            step();
            if (i == 65534) chk("cnt_max", 32'(word_cnt), 32'h0000FFFF);
        end
        chk("cnt_wrap", 32'(word_cnt), 32'd0);
        in_valid = 1'b0;
        step();

`ifdef HC_ERR_INJECT_EN
        rst = 1'b1;
        step();
        rst        = 1'b0;
        inj_en     = 1'b1;
        inj_period = 8'd4;
        inj_pos    = 5'd5;
        inj_double = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'h0000;
        for (int w = 1; w <= 8; w++) begin
            inj_xor = (w % 4 == 0) ? 22'h000020 : 22'h000000;
            step();
            chk("inj_word", 32'(out_code), (w % 4 == 0) ? 32'h20 : 32'h0);
        end
        in_valid = 1'b0;
        inj_en   = 1'b0;
        inj_xor  = 22'd0;
        step();
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
